// File: rtl/dec_seq_ctrl.sv
// Block-alignment sequencer for the receive decoder: hunts for sync headers,
// locks after a run of good ones and drops lock after a run of bad/missing ones.
module dec_seq_ctrl #(
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned ERR_MAX  = 3
) (
   input  logic       enc_clk,
   input  logic       rst,
   input  logic       rx_en,
   input  logic [1:0] gen_speed,
   input  logic       sync_hdr_vld,
   input  logic [3:0] sync_hdr,
   input  logic [3:0] d_sel_cfg,
   output logic       enable_dec,
   output logic [3:0] d_sel,
   output logic       block_lock,
   output logic       sync_err,
   output logic [3:0] byte_cnt,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_CNT);
   localparam logic [3:0] ERR_MAX_C  = 4'(ERR_MAX);

   // Block period minus one doubles as the modulo mask (periods are powers of two).
   function automatic logic [3:0] period_mask(input logic [1:0] gen);
      case (gen)
         2'd0:    period_mask = 4'd0;
         2'd1:    period_mask = 4'd15;
         2'd2:    period_mask = 4'd7;
         default: period_mask = 4'd0;
      endcase
   endfunction

   function automatic logic hdr_good(input logic [1:0] gen, input logic [3:0] hdr);
      case (gen)
         2'd0:    hdr_good = 1'b1;
         2'd1:    hdr_good = (hdr == 4'b0101) || (hdr == 4'b1010);
         2'd2:    hdr_good = (hdr[1:0] == 2'b01) || (hdr[1:0] == 2'b10);
         default: hdr_good = 1'b0;
      endcase
   endfunction

   state_t     r_state;
   logic [1:0] r_gen;
   logic [3:0] r_good_cnt;
   logic [3:0] r_err_cnt;
   logic [3:0] r_byte_cnt;
   logic [3:0] r_d_sel;
   logic       r_enable_dec;
   logic       r_block_lock;
   logic       r_sync_err;

   logic [3:0] w_mask;
   logic [3:0] w_byte_nxt;
   logic [3:0] w_byte_one;
   logic [3:0] w_good_inc;
   logic [3:0] w_err_inc;
   logic       w_hdr_good;
   logic       w_force_idle;

   assign w_mask       = period_mask(r_gen);
   assign w_byte_nxt   = (r_byte_cnt + 4'd1) & w_mask;
   assign w_byte_one   = 4'd1 & w_mask;
   assign w_good_inc   = (r_good_cnt == 4'd15) ? 4'd15 : r_good_cnt + 4'd1;
   assign w_err_inc    = (r_err_cnt == 4'd15) ? 4'd15 : r_err_cnt + 4'd1;
   assign w_hdr_good   = sync_hdr_vld && hdr_good(r_gen, sync_hdr);
   assign w_force_idle = !rx_en || (gen_speed != r_gen);

   // Sequencer state, counters and all registered outputs.
   always_ff @(posedge enc_clk) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_gen        <= gen_speed;
         r_good_cnt   <= 4'd0;
         r_err_cnt    <= 4'd0;
         r_byte_cnt   <= 4'd0;
         r_d_sel      <= 4'd0;
         r_enable_dec <= 1'b0;
         r_block_lock <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_gen      <= gen_speed;
         r_sync_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_good_cnt   <= 4'd0;
               r_err_cnt    <= 4'd0;
               r_byte_cnt   <= 4'd0;
               r_enable_dec <= 1'b0;
               r_block_lock <= 1'b0;
               if (rx_en && (gen_speed != 2'd3)) begin
                  r_state <= ST_HUNT;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_HUNT: begin
               if (w_force_idle) begin
                  r_state    <= ST_IDLE;
                  r_good_cnt <= 4'd0;
                  r_err_cnt  <= 4'd0;
                  r_byte_cnt <= 4'd0;
               end else if (w_hdr_good) begin
                  // A good header marks byte 0 of the block.
                  r_byte_cnt <= w_byte_one;
                  r_good_cnt <= w_good_inc;
                  if (w_good_inc >= LOCK_CNT_C) begin
                     r_state      <= ST_LOCKED;
                     r_err_cnt    <= 4'd0;
                     r_enable_dec <= 1'b1;
                     r_block_lock <= 1'b1;
                  end else begin
                     r_state <= ST_HUNT;
                  end
               end else begin
                  r_byte_cnt <= w_byte_nxt;
                  if (sync_hdr_vld) begin
                     r_good_cnt <= 4'd0;
                  end else begin
                     r_good_cnt <= r_good_cnt;
                  end
               end
            end
            ST_LOCKED: begin
               if (w_force_idle) begin
                  r_state      <= ST_IDLE;
                  r_good_cnt   <= 4'd0;
                  r_err_cnt    <= 4'd0;
                  r_byte_cnt   <= 4'd0;
                  r_enable_dec <= 1'b0;
                  r_block_lock <= 1'b0;
               end else begin
                  r_byte_cnt <= w_byte_nxt;
                  if (r_byte_cnt == w_mask) begin
                     r_d_sel <= d_sel_cfg;
                  end else begin
                     r_d_sel <= r_d_sel;
                  end
                  // Header expected only at byte 0; a header elsewhere is an error too.
                  if ((r_byte_cnt == 4'd0) && w_hdr_good) begin
                     r_err_cnt <= 4'd0;
                  end else if ((r_byte_cnt == 4'd0) || sync_hdr_vld) begin
                     r_sync_err <= 1'b1;
                     if (w_err_inc >= ERR_MAX_C) begin
                        r_state      <= ST_HUNT;
                        r_good_cnt   <= 4'd0;
                        r_err_cnt    <= 4'd0;
                        r_enable_dec <= 1'b0;
                        r_block_lock <= 1'b0;
                     end else begin
                        r_err_cnt <= w_err_inc;
                     end
                  end else begin
                     r_err_cnt <= r_err_cnt;
                  end
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_good_cnt   <= 4'd0;
               r_err_cnt    <= 4'd0;
               r_byte_cnt   <= 4'd0;
               r_enable_dec <= 1'b0;
               r_block_lock <= 1'b0;
            end
         endcase
      end
   end

   assign enable_dec = r_enable_dec;
   assign d_sel      = r_d_sel;
   assign block_lock = r_block_lock;
   assign sync_err   = r_sync_err;
   assign byte_cnt   = r_byte_cnt;
   assign state      = r_state;

endmodule

// File: tb/tb_dec_seq_ctrl.sv
// Table-driven bench for dec_seq_ctrl: every row gives inputs for one clock edge
// and the outputs expected just after it, checked through a scoreboard queue.
module tb_dec_seq_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HUNT = 2'd1;
   localparam logic [1:0] S_LOCK = 2'd2;

   typedef struct packed {
      logic        rst_n;
      logic        rx;
      logic [1:0]  gen;
      logic        vld;
      logic [3:0]  hdr;
      logic [3:0]  cfg;
      logic [1:0]  st;
      logic        en;
      logic        lk;
      logic        se;
      logic [3:0]  bc;
      logic [3:0]  ds;
      logic [63:0] tag;
   } vec_t;

   logic       enc_clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_en = 1'b0;
   logic [1:0] gen_speed = 2'd2;
   logic       sync_hdr_vld = 1'b0;
   logic [3:0] sync_hdr = 4'd0;
   logic [3:0] d_sel_cfg = 4'd0;
   logic       enable_dec;
   logic [3:0] d_sel;
   logic       block_lock;
   logic       sync_err;
   logic [3:0] byte_cnt;
   logic [1:0] state;

   vec_t        vt[$];
   logic [12:0] sb_q[$];
   logic [63:0] tag_q[$];
   logic [63:0] cur_tag;
   int          n_tests = 0;
   int          n_fail  = 0;

   dec_seq_ctrl #(.LOCK_CNT(4), .ERR_MAX(3)) dut (
      .enc_clk      (enc_clk),
      .rst          (rst),
      .rx_en        (rx_en),
      .gen_speed    (gen_speed),
      .sync_hdr_vld (sync_hdr_vld),
      .sync_hdr     (sync_hdr),
      .d_sel_cfg    (d_sel_cfg),
      .enable_dec   (enable_dec),
      .d_sel        (d_sel),
      .block_lock   (block_lock),
      .sync_err     (sync_err),
      .byte_cnt     (byte_cnt),
      .state        (state)
   );

   always #5 enc_clk = ~enc_clk;

   function automatic void add(input logic r, input logic x, input logic [1:0] g,
                               input logic v, input logic [3:0] h, input logic [3:0] c,
                               input logic [1:0] st, input logic en, input logic lk,
                               input logic se, input logic [3:0] bc, input logic [3:0] ds);
      vec_t e;
      e.rst_n = r; e.rx = x; e.gen = g; e.vld = v; e.hdr = h; e.cfg = c;
      e.st = st; e.en = en; e.lk = lk; e.se = se; e.bc = bc; e.ds = ds;
      e.tag = cur_tag;
      vt.push_back(e);
   endfunction

   // Header-free rows from byte j0 up to the wrap to 0; d_sel may change on the wrap row.
   function automatic void blk(input logic [1:0] g, input int p, input logic [3:0] c,
                               input logic [1:0] st, input logic lk,
                               input logic [3:0] ds_mid, input logic [3:0] ds_last, input int j0);
      for (int j = j0; j <= p; j++) begin
         add(1'b1, 1'b1, g, 1'b0, 4'd0, c, st, lk, lk, 1'b0, 4'(j % p),
             (j == p) ? ds_last : ds_mid);
      end
   endfunction

   task automatic check_out();
      logic [12:0] act;
      logic [12:0] exp;
      logic [63:0] tg;
      act = {state, enable_dec, block_lock, sync_err, byte_cnt, d_sel};
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %b, no expected entry", act);
      end else begin
         exp = sb_q.pop_front();
         tg  = tag_q.pop_front();
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got st=%0d en=%0d lk=%0d se=%0d bc=%0d ds=%0d, expected st=%0d en=%0d lk=%0d se=%0d bc=%0d ds=%0d",
                     tg, $time, act[12:11], act[10], act[9], act[8], act[7:4], act[3:0],
                     exp[12:11], exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
         end
      end
   endtask

   task automatic apply(input vec_t v);
      rst          = v.rst_n;
      rx_en        = v.rx;
      gen_speed    = v.gen;
      sync_hdr_vld = v.vld;
      sync_hdr     = v.hdr;
      d_sel_cfg    = v.cfg;
      sb_q.push_back({v.st, v.en, v.lk, v.se, v.bc, v.ds});
      tag_q.push_back(v.tag);
      @(posedge enc_clk);
      #1;
      check_out();
   endtask

   initial begin
      logic [3:0] g3_hdrs [7];
      g3_hdrs = '{4'b0101, 4'b1010, 4'b0000, 4'b0101, 4'b1010, 4'b0101, 4'b1010};

      cur_tag = "RESET";
      add(1'b0, 1'b1, 2'd2, 1'b0, 4'd0, 4'd0, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      add(1'b0, 1'b1, 2'd2, 1'b1, 4'd1, 4'd0, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

      cur_tag = "G2LOCK";
      add(1'b1, 1'b1, 2'd2, 1'b0, 4'd0, 4'd0, S_HUNT, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      for (int h = 1; h <= 4; h++) begin
         add(1'b1, 1'b1, 2'd2, 1'b1, (h % 2 == 1) ? 4'b0001 : 4'b0010, 4'd0,
             (h == 4) ? S_LOCK : S_HUNT, h == 4, h == 4, 1'b0, 4'd1, 4'd0);
         blk(2'd2, 8, 4'd0, (h == 4) ? S_LOCK : S_HUNT, h == 4, 4'd0, 4'd0, 2);
      end

      cur_tag = "G2DSEL";
      add(1'b1, 1'b1, 2'd2, 1'b1, 4'b0001, 4'd0, S_LOCK, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0);
      add(1'b1, 1'b1, 2'd2, 1'b0, 4'd0,    4'd0, S_LOCK, 1'b1, 1'b1, 1'b0, 4'd2, 4'd0);
      add(1'b1, 1'b1, 2'd2, 1'b0, 4'd0,    4'd0, S_LOCK, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0);
      blk(2'd2, 8, 4'd8, S_LOCK, 1'b1, 4'd0, 4'd8, 4);

      cur_tag = "G2MIDHDR";
      add(1'b1, 1'b1, 2'd2, 1'b1, 4'b0001, 4'd8, S_LOCK, 1'b1, 1'b1, 1'b0, 4'd1, 4'd8);
      add(1'b1, 1'b1, 2'd2, 1'b1, 4'b0001, 4'd8, S_LOCK, 1'b1, 1'b1, 1'b1, 4'd2, 4'd8);
      blk(2'd2, 8, 4'd8, S_LOCK, 1'b1, 4'd8, 4'd8, 3);
      add(1'b1, 1'b1, 2'd2, 1'b1, 4'b0010, 4'd8, S_LOCK, 1'b1, 1'b1, 1'b0, 4'd1, 4'd8);
      blk(2'd2, 8, 4'd8, S_LOCK, 1'b1, 4'd8, 4'd8, 2);

      cur_tag = "G2TOG3";
      add(1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 4'd3, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd8);
      add(1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 4'd3, S_HUNT, 1'b0, 1'b0, 1'b0, 4'd0, 4'd8);

      cur_tag = "G3HUNT";
      for (int i = 0; i < 7; i++) begin
         add(1'b1, 1'b1, 2'd1, 1'b1, g3_hdrs[i], 4'd3, (i == 6) ? S_LOCK : S_HUNT,
             i == 6, i == 6, 1'b0, 4'd1, 4'd8);
         blk(2'd1, 16, 4'd3, (i == 6) ? S_LOCK : S_HUNT, i == 6, 4'd8,
             (i == 6) ? 4'd3 : 4'd8, 2);
      end

      cur_tag = "G3ERR2";
      add(1'b1, 1'b1, 2'd1, 1'b1, 4'b0000, 4'd3, S_LOCK, 1'b1, 1'b1, 1'b1, 4'd1, 4'd3);
      blk(2'd1, 16, 4'd3, S_LOCK, 1'b1, 4'd3, 4'd3, 2);
      add(1'b1, 1'b1, 2'd1, 1'b0, 4'b0000, 4'd3, S_LOCK, 1'b1, 1'b1, 1'b1, 4'd1, 4'd3);
      blk(2'd1, 16, 4'd3, S_LOCK, 1'b1, 4'd3, 4'd3, 2);
      add(1'b1, 1'b1, 2'd1, 1'b1, 4'b1010, 4'd3, S_LOCK, 1'b1, 1'b1, 1'b0, 4'd1, 4'd3);
      blk(2'd1, 16, 4'd3, S_LOCK, 1'b1, 4'd3, 4'd3, 2);

      cur_tag = "G3DROP";
      for (int i = 1; i <= 3; i++) begin
         add(1'b1, 1'b1, 2'd1, 1'b1, 4'b0000, 4'd3, (i == 3) ? S_HUNT : S_LOCK,
             i != 3, i != 3, 1'b1, 4'd1, 4'd3);
         blk(2'd1, 16, 4'd3, (i == 3) ? S_HUNT : S_LOCK, i != 3, 4'd3, 4'd3, 2);
      end

      cur_tag = "G4";
      add(1'b1, 1'b1, 2'd0, 1'b0, 4'd0, 4'd5, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3);
      add(1'b1, 1'b1, 2'd0, 1'b0, 4'd0, 4'd5, S_HUNT, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3);
      for (int i = 1; i <= 4; i++) begin
         add(1'b1, 1'b1, 2'd0, 1'b1, 4'(i * 3), 4'd5, (i == 4) ? S_LOCK : S_HUNT,
             i == 4, i == 4, 1'b0, 4'd0, 4'd3);
      end
      add(1'b1, 1'b1, 2'd0, 1'b1, 4'hF, 4'd5, S_LOCK, 1'b1, 1'b1, 1'b0, 4'd0, 4'd5);
      add(1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 4'd5, S_LOCK, 1'b1, 1'b1, 1'b1, 4'd0, 4'd5);
      add(1'b1, 1'b1, 2'd0, 1'b1, 4'h7, 4'd5, S_LOCK, 1'b1, 1'b1, 1'b0, 4'd0, 4'd5);

      cur_tag = "GENCHG";
      add(1'b1, 1'b1, 2'd1, 1'b1, 4'h3, 4'd9, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5);
      add(1'b1, 1'b1, 2'd1, 1'b0, 4'h0, 4'd9, S_HUNT, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5);
      add(1'b1, 1'b1, 2'd3, 1'b0, 4'h0, 4'd9, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5);
      add(1'b1, 1'b1, 2'd3, 1'b1, 4'h5, 4'd9, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5);
      add(1'b1, 1'b1, 2'd3, 1'b0, 4'h0, 4'd9, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5);

      cur_tag = "G2RELOCK";
      add(1'b1, 1'b1, 2'd2, 1'b0, 4'd0, 4'd6, S_HUNT, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5);
      for (int h = 1; h <= 4; h++) begin
         add(1'b1, 1'b1, 2'd2, 1'b1, 4'b0001, 4'd6, (h == 4) ? S_LOCK : S_HUNT,
             h == 4, h == 4, 1'b0, 4'd1, 4'd5);
         blk(2'd2, 8, 4'd6, (h == 4) ? S_LOCK : S_HUNT, h == 4, 4'd5,
             (h == 4) ? 4'd6 : 4'd5, 2);
      end
      add(1'b1, 1'b1, 2'd2, 1'b1, 4'b0010, 4'd6, S_LOCK, 1'b1, 1'b1, 1'b0, 4'd1, 4'd6);
      for (int j = 2; j <= 5; j++) begin
         add(1'b1, 1'b1, 2'd2, 1'b0, 4'd0, 4'd6, S_LOCK, 1'b1, 1'b1, 1'b0, 4'(j), 4'd6);
      end

      cur_tag = "MIDRST";
      add(1'b0, 1'b1, 2'd2, 1'b1, 4'b0001, 4'd6, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      add(1'b1, 1'b1, 2'd2, 1'b0, 4'd0,    4'd6, S_HUNT, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      for (int h = 1; h <= 4; h++) begin
         add(1'b1, 1'b1, 2'd2, 1'b1, 4'b0010, 4'd6, (h == 4) ? S_LOCK : S_HUNT,
             h == 4, h == 4, 1'b0, 4'd1, 4'd0);
         blk(2'd2, 8, 4'd6, (h == 4) ? S_LOCK : S_HUNT, h == 4, 4'd0,
             (h == 4) ? 4'd6 : 4'd0, 2);
      end

      cur_tag = "RXOFF";
      add(1'b1, 1'b0, 2'd2, 1'b1, 4'b0000, 4'd6, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd6);
      add(1'b1, 1'b0, 2'd2, 1'b1, 4'b0001, 4'd6, S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 4'd6);

      foreach (vt[k]) begin
         apply(vt[k]);
      end

      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
